tgroup_launcher: RTL and testbench

// Upstream neighbour of thread_dispatcher. Accepts one kernel launch (pc, dp_addr, total

---
 rtl/tgroup_launcher_if.sv | 38 +++
 rtl/tgroup_launcher.sv | 95 +++++++++
 tb/tb_tgroup_launcher.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/tgroup_launcher_if.sv
// Launch request, group dispatch and tblock-completion signals of tgroup_launcher.
// The slave modport is the launcher itself; the master modport is its environment.
interface tgroup_launcher_if #(
  parameter int PcWidth          = 16,
  parameter int AddressWidth     = 32,
  parameter int TblockIdxBits    = 5,
  parameter int TgroupIdBits     = 8,
  parameter int KernelTblockBits = 16
);
  logic                        launch_valid_i;
  logic                        launch_ready_o;
  logic [PcWidth-1:0]          launch_pc_i;
  logic [AddressWidth-1:0]     launch_dp_addr_i;
  logic [KernelTblockBits-1:0] launch_num_tblocks_i;
  logic                        start_o;
  logic                        ready_i;
  logic [PcWidth-1:0]          pc_o;
  logic [AddressWidth-1:0]     dp_addr_o;
  logic [TblockIdxBits-1:0]    number_of_tblocks_o;
  logic [TgroupIdBits-1:0]     tgroup_id_o;
  logic                        tblock_done_i;
  logic                        kernel_done_o;
  logic                        busy_o;

  modport slave (
    input  launch_valid_i, launch_pc_i, launch_dp_addr_i, launch_num_tblocks_i,
           ready_i, tblock_done_i,
    output launch_ready_o, start_o, pc_o, dp_addr_o, number_of_tblocks_o,
           tgroup_id_o, kernel_done_o, busy_o
  );

  modport master (
    output launch_valid_i, launch_pc_i, launch_dp_addr_i, launch_num_tblocks_i,
           ready_i, tblock_done_i,
    input  launch_ready_o, start_o, pc_o, dp_addr_o, number_of_tblocks_o,
           tgroup_id_o, kernel_done_o, busy_o
  );
endinterface

// File: rtl/tgroup_launcher.sv
// Splits one kernel launch into groups of up to 2**TblockIdxBits-1 tblocks, offers them over start/ready,
// counts completions; launch->first start 1 cycle, last done->kernel_done_o 1 cycle, groups hold while !ready_i.
module tgroup_launcher #(
  parameter int PcWidth          = 16,
  parameter int AddressWidth     = 32,
  parameter int TblockIdxBits    = 5,
  parameter int TgroupIdBits     = 8,
  parameter int KernelTblockBits = 16
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  tgroup_launcher_if.slave   bus
);
  localparam logic [KernelTblockBits-1:0] MaxGrp =
    KernelTblockBits'((1 << TblockIdxBits) - 1);

  typedef enum logic [1:0] {IDLE, DISPATCH, WAIT_DONE, DONE} state_e;

  state_e                      state_q, state_d;
  logic [PcWidth-1:0]          pc_q;
  logic [AddressWidth-1:0]     dp_q;
  logic [KernelTblockBits-1:0] remaining_q;
  logic [KernelTblockBits-1:0] total_q;
  logic [KernelTblockBits-1:0] done_cnt_q, done_cnt_d;
  logic [TgroupIdBits-1:0]     tgroup_id_q;
  logic [KernelTblockBits-1:0] grp_n;
  logic                        launch_hs, group_hs, counting, done_inc;

  assign grp_n     = (remaining_q > MaxGrp) ? MaxGrp : remaining_q;
  assign launch_hs = (state_q == IDLE) && bus.launch_valid_i;
  assign group_hs  = (state_q == DISPATCH) && bus.ready_i;
  assign counting  = (state_q == DISPATCH) || (state_q == WAIT_DONE);
  // Saturate at total: excess completions are a protocol error flagged below.
  assign done_inc   = counting && bus.tblock_done_i && (done_cnt_q != total_q);
  assign done_cnt_d = done_cnt_q + KernelTblockBits'(done_inc);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:      if (bus.launch_valid_i)
                   state_d = (bus.launch_num_tblocks_i == '0) ? DONE : DISPATCH;
      DISPATCH:  if (group_hs && (remaining_q == grp_n)) state_d = WAIT_DONE;
      WAIT_DONE: if (done_cnt_d == total_q) state_d = DONE;
      DONE:      state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.launch_ready_o = (state_q == IDLE);
    bus.start_o        = (state_q == DISPATCH);
    bus.kernel_done_o  = (state_q == DONE);
    bus.busy_o         = (state_q != IDLE);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pc_q        <= '0;
      dp_q        <= '0;
      remaining_q <= '0;
      total_q     <= '0;
      done_cnt_q  <= '0;
      tgroup_id_q <= '0;
    end else if (launch_hs) begin
      pc_q        <= bus.launch_pc_i;
      dp_q        <= bus.launch_dp_addr_i;
      remaining_q <= bus.launch_num_tblocks_i;
      total_q     <= bus.launch_num_tblocks_i;
      done_cnt_q  <= '0;
      tgroup_id_q <= '0;
    end else begin
      done_cnt_q <= done_cnt_d;
      if (group_hs) begin
        remaining_q <= remaining_q - grp_n;
        tgroup_id_q <= tgroup_id_q + 1'b1;
      end
    end
  end

  assign bus.pc_o                = pc_q;
  assign bus.dp_addr_o           = dp_q;
  assign bus.number_of_tblocks_o = grp_n[TblockIdxBits-1:0];
  assign bus.tgroup_id_o         = tgroup_id_q;

  a_no_excess_done: assert property (@(posedge clk_i) disable iff (!rst_ni)
    (counting && bus.tblock_done_i) |-> (done_cnt_q != total_q));
endmodule

// File: tb/tb_tgroup_launcher.sv
// Directed bench for tgroup_launcher: cycle-level vector table plus hand sequences
// for long kernels, launch blocking, done pulses during dispatch and mid-kernel reset.
module tb_tgroup_launcher;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   pass_cnt = 0;
  int   tot_cnt = 0;

  always #5 clk = ~clk;

  tgroup_launcher_if intf ();

  tgroup_launcher dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (intf.slave)
  );

  typedef struct {
    logic        lv;
    logic [15:0] num;
    logic        rdy;
    logic        td;
    logic        e_lr;
    logic        e_busy;
    logic        e_start;
    logic [4:0]  e_n;
    logic [7:0]  e_id;
    logic        e_kd;
  } vec_t;

  vec_t vecs[11];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tot_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic launch(input int num, input logic [15:0] pc, input logic [31:0] dp);
    intf.launch_valid_i       = 1'b1;
    intf.launch_num_tblocks_i = 16'(num);
    intf.launch_pc_i          = pc;
    intf.launch_dp_addr_i     = dp;
    tick();
    intf.launch_valid_i = 1'b0;
  endtask

  // Golden splitter: every offered group is compared against the expected size/ID sequence.
  task automatic run_kernel(input int num, input logic [15:0] pc, input logic [31:0] dp);
    int  rem, id, n, budget;
    bit  early;
    chk("idle_ready", 32'(intf.launch_ready_o), 32'(1));
    launch(num, pc, dp);
    intf.ready_i = 1'b1;
    rem = num; id = 0; budget = 0;
    while (rem > 0 && budget < 500) begin
      n = (rem > 31) ? 31 : rem;
      chk("grp_start", 32'(intf.start_o), 32'(1));
      chk("grp_n", 32'(intf.number_of_tblocks_o), 32'(n));
      chk("grp_id", 32'(intf.tgroup_id_o), 32'(id));
      chk("grp_pc", 32'(intf.pc_o), 32'(pc));
      chk("grp_dp", intf.dp_addr_o, dp);
      tick();
      rem -= n; id = (id + 1) % 256; budget++;
    end
    intf.ready_i = 1'b0;
    chk("post_disp_start", 32'(intf.start_o), 32'(0));
    chk("post_disp_busy", 32'(intf.busy_o), 32'(1));
    early = 1'b0;
    for (int i = 0; i < num; i++) begin
      if (intf.kernel_done_o) early = 1'b1;
      intf.tblock_done_i = 1'b1;
      tick();
    end
    intf.tblock_done_i = 1'b0;
    chk("kd_early", 32'(early), 32'(0));
    chk("kd_pulse", 32'(intf.kernel_done_o), 32'(1));
    tick();
    chk("kd_single", 32'(intf.kernel_done_o), 32'(0));
    chk("ready_back", 32'(intf.launch_ready_o), 32'(1));
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish, expected end before 500us");
    $fatal(1, "timeout");
  end

  initial begin
    int  kdcnt;
    bit  bad, seen;

    //        lv num  rdy td  lr busy st n   id kd
    vecs[0]  = '{1, 0,  0, 0,  1, 0,  0, 0,  0, 0};
    vecs[1]  = '{0, 0,  0, 0,  0, 1,  0, 0,  0, 1};
    vecs[2]  = '{1, 40, 0, 0,  1, 0,  0, 0,  0, 0};
    for (int i = 3; i < 8; i++)
      vecs[i] = '{0, 0, 0, 0,  0, 1,  1, 31, 0, 0};
    vecs[8]  = '{0, 0,  1, 0,  0, 1,  1, 31, 0, 0};
    vecs[9]  = '{0, 0,  1, 1,  0, 1,  1, 9,  1, 0};
    vecs[10] = '{0, 0,  0, 0,  0, 1,  0, 0,  2, 0};

    intf.launch_valid_i       = 1'b0;
    intf.launch_pc_i          = '0;
    intf.launch_dp_addr_i     = '0;
    intf.launch_num_tblocks_i = '0;
    intf.ready_i              = 1'b0;
    intf.tblock_done_i        = 1'b0;

    repeat (3) @(negedge clk);
    chk("rst_ready", 32'(intf.launch_ready_o), 32'(1));
    chk("rst_busy", 32'(intf.busy_o), 32'(0));
    chk("rst_start", 32'(intf.start_o), 32'(0));
    chk("rst_kd", 32'(intf.kernel_done_o), 32'(0));
    chk("rst_id", 32'(intf.tgroup_id_o), 32'(0));
    rst_n = 1'b1;
    @(negedge clk);

    // Table: zero-tblock kernel, then a 40-tblock kernel stalled 5 cycles on its first group.
    for (int i = 0; i < 11; i++) begin
      chk($sformatf("vec%0d_ready", i), 32'(intf.launch_ready_o), 32'(vecs[i].e_lr));
      chk($sformatf("vec%0d_busy", i), 32'(intf.busy_o), 32'(vecs[i].e_busy));
      chk($sformatf("vec%0d_start", i), 32'(intf.start_o), 32'(vecs[i].e_start));
      chk($sformatf("vec%0d_n", i), 32'(intf.number_of_tblocks_o), 32'(vecs[i].e_n));
      chk($sformatf("vec%0d_id", i), 32'(intf.tgroup_id_o), 32'(vecs[i].e_id));
      chk($sformatf("vec%0d_kd", i), 32'(intf.kernel_done_o), 32'(vecs[i].e_kd));
      intf.launch_valid_i       = vecs[i].lv;
      intf.launch_num_tblocks_i = vecs[i].num;
      intf.ready_i              = vecs[i].rdy;
      intf.tblock_done_i        = vecs[i].td;
      tick();
    end
    for (int i = 0; i < 39; i++) begin
      intf.tblock_done_i = 1'b1;
      tick();
    end
    intf.tblock_done_i = 1'b0;
    chk("t3_kd", 32'(intf.kernel_done_o), 32'(1));
    tick();
    chk("t3_idle", 32'(intf.launch_ready_o), 32'(1));

    // 70 tblocks -> 31, 31, 8
    run_kernel(70, 16'h0100, 32'h0000_A000);

    // launch_valid_i held high throughout a 3-tblock kernel
    intf.launch_valid_i       = 1'b1;
    intf.launch_num_tblocks_i = 16'd3;
    intf.ready_i              = 1'b1;
    bad = 1'b0; seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (intf.kernel_done_o) begin
        seen = 1'b1;
        break;
      end
      if (intf.launch_ready_o) bad = 1'b1;
      intf.tblock_done_i = !intf.start_o;
    end
    intf.tblock_done_i = 1'b0;
    intf.ready_i       = 1'b0;
    chk("t4_kd_seen", 32'(seen), 32'(1));
    chk("t4_ready_while_busy", 32'(bad), 32'(0));
    chk("t4_ready_on_done", 32'(intf.launch_ready_o), 32'(0));
    tick();
    chk("t4_ready_after", 32'(intf.launch_ready_o), 32'(1));
    intf.launch_valid_i = 1'b0;
    tick();

    // 31 tblocks, completions during DISPATCH and on the handshake cycle
    launch(31, 16'h0300, 32'h0000_C000);
    intf.ready_i = 1'b0;
    intf.tblock_done_i = 1'b1;
    repeat (3) tick();
    chk("t5_start", 32'(intf.start_o), 32'(1));
    chk("t5_n", 32'(intf.number_of_tblocks_o), 32'(31));
    intf.ready_i = 1'b1;
    tick();
    intf.ready_i = 1'b0;
    chk("t5_wait", 32'(intf.start_o), 32'(0));
    kdcnt = 0;
    for (int i = 0; i < 27; i++) begin
      if (intf.kernel_done_o) kdcnt++;
      tick();
    end
    intf.tblock_done_i = 1'b0;
    chk("t5_kd", 32'(intf.kernel_done_o), 32'(1));
    for (int i = 0; i < 4; i++) begin
      tick();
      if (intf.kernel_done_o) kdcnt++;
    end
    chk("t5_kd_extra", 32'(kdcnt), 32'(0));

    // reset while the third group of a 100-tblock kernel is offered
    launch(100, 16'h0400, 32'h0000_D000);
    intf.ready_i = 1'b1;
    repeat (2) tick();
    intf.ready_i = 1'b0;
    chk("t6_pre_id", 32'(intf.tgroup_id_o), 32'(2));
    rst_n = 1'b0;
    #1;
    chk("t6_rst_start", 32'(intf.start_o), 32'(0));
    chk("t6_rst_ready", 32'(intf.launch_ready_o), 32'(1));
    chk("t6_rst_busy", 32'(intf.busy_o), 32'(0));
    chk("t6_rst_id", 32'(intf.tgroup_id_o), 32'(0));
    chk("t6_rst_kd", 32'(intf.kernel_done_o), 32'(0));
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_kernel(5, 16'h0200, 32'h0000_B000);

    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end
endmodule
